// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Drives open-drain pull-low enables for PS2_CLK/PS2_DAT; reports sent, NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000,
  parameter int TIMER_W        = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       tx_nack,
  output logic       error_communication_timed_out
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_INHIBIT    = 3'd1;
  localparam logic [2:0] S_REQ        = 3'd2;
  localparam logic [2:0] S_WAIT_FIRST = 3'd3;
  localparam logic [2:0] S_DATA       = 3'd4;
  localparam logic [2:0] S_WAIT_ACK   = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE  = 3'd6;
  localparam logic [2:0] S_TIMEOUT    = 3'd7;

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST     = TIMER_W'(BIT_TIMEOUT - 1);

  logic [2:0]         state;
  logic [9:0]         shift;
  logic [3:0]         bit_count;
  logic [TIMER_W-1:0] timer;
  logic               dat_oe;
  logic               clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
  logic               fall, bit_expired;

  // Sync registers reset high so an idle bus never looks like a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      {clk_meta, clk_sync, clk_prev, dat_meta, dat_sync} <= '1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  assign fall        = clk_prev & ~clk_sync;
  assign bit_expired = (timer >= BIT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state            <= S_IDLE;
      shift            <= '0;
      bit_count        <= '0;
      timer            <= '0;
      dat_oe           <= 1'b0;
      command_was_sent <= 1'b0;
      tx_nack          <= 1'b0;
    end else begin
      command_was_sent <= 1'b0;
      tx_nack          <= 1'b0;
      if (timer != '1) timer <= timer + 1'b1;
      case (state)
        S_IDLE: begin
          dat_oe <= 1'b0;
          if (send_command) begin
            shift     <= {1'b1, ~^the_command, the_command};
            timer     <= '0;
            bit_count <= '0;
            state     <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (timer >= INHIBIT_LAST) begin
            dat_oe <= 1'b1;
            timer  <= '0;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          timer <= '0;
          state <= S_WAIT_FIRST;
        end
        S_WAIT_FIRST: begin
          if (fall) begin
            dat_oe    <= ~shift[0];
            shift     <= {1'b0, shift[9:1]};
            bit_count <= 4'd1;
            timer     <= '0;
            state     <= S_DATA;
          end else if (timer >= START_LAST) begin
            dat_oe <= 1'b0;
            state  <= S_TIMEOUT;
          end
        end
        // Falls 2..10 present d1..d7, parity, then stop; the device samples on rise.
        S_DATA: begin
          if (fall) begin
            dat_oe    <= ~shift[0];
            shift     <= {1'b0, shift[9:1]};
            bit_count <= bit_count + 4'd1;
            timer     <= '0;
            if (bit_count == 4'd9) state <= S_WAIT_ACK;
          end else if (bit_expired) begin
            dat_oe <= 1'b0;
            state  <= S_TIMEOUT;
          end
        end
        S_WAIT_ACK: begin
          if (fall) begin
            timer <= '0;
            if (dat_sync) begin
              tx_nack <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_WAIT_IDLE;
            end
          end else if (bit_expired) begin
            state <= S_TIMEOUT;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_sync && dat_sync) begin
            command_was_sent <= 1'b1;
            state            <= S_IDLE;
          end else if (bit_expired) begin
            state <= S_TIMEOUT;
          end
        end
        default: begin
          dat_oe <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe                    = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2_dat_oe                    = dat_oe;
  assign busy                          = (state != S_IDLE);
  assign error_communication_timed_out = (state == S_TIMEOUT);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx
// A PS/2 device model clocks frames out of the DUT; a scoreboard checks outcomes and timing.
module tb_ps2_host_tx;
  localparam int INH   = 40;
  localparam int START = 600;
  localparam int BIT   = 200;
  localparam int TW    = 12;
  localparam int H     = 15;
  localparam int K_SENT = 1, K_NACK = 2, K_TO = 3;

  logic CLOCK_50 = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] the_command = 8'h00;
  logic send_command = 1'b0;
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic line_clk, line_dat;
  logic ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, tx_nack, error_communication_timed_out;

  assign line_clk = ~(ps2_clk_oe | dev_clk_low);
  assign line_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT(START), .BIT_TIMEOUT(BIT), .TIMER_W(TW)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .the_command(the_command), .send_command(send_command),
    .ps2_clk_in(line_clk), .ps2_dat_in(line_dat), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .command_was_sent(command_was_sent), .tx_nack(tx_nack),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  logic [5:0] hist = '1;
  bit rst_edge = 1'b1;
  int exp_q[$];
  int to_mode = 0;
  int last_fall_cyc = 0, clk_rel_cyc = 0;
  logic [10:0] dev_obs;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  always @(posedge CLOCK_50) begin
    cyc = cyc + 1;
    hist = {hist[4:0], line_clk};
    rst_edge = !resetn;
  end

  // Per-cycle compare process
  logic p_clk_oe = 0, p_dat_oe = 0, p_busy = 0, p_err = 0, p_pulse = 0;
  int inh_run = 0, req_run = 0;
  always @(negedge CLOCK_50) begin
    bit any_pulse, recent_fall, legal;
    int kind;
    if (rst_edge) begin
      inh_run = 0;
      req_run = 0;
    end else begin
      any_pulse = command_was_sent | tx_nack | error_communication_timed_out;
      if (any_pulse) begin
        chk("pulse_onehot", $countones({command_was_sent, tx_nack, error_communication_timed_out}), 1);
        chk("pulse_width", p_pulse, 0);
        kind = command_was_sent ? K_SENT : (tx_nack ? K_NACK : K_TO);
        if (exp_q.size() == 0) chk("unexpected_pulse", kind, 0);
        else chk("pulse_kind", kind, exp_q.pop_front());
        if (kind != K_TO) begin
          chk("busy_at_done", busy, 0);
        end else begin
          chk("oe_at_timeout", {ps2_clk_oe, ps2_dat_oe}, 0);
          chk("busy_at_timeout", busy, 1);
          if (to_mode == 1) chk_near("start_timeout_delay", cyc - clk_rel_cyc, START, 3);
          else chk_near("bit_timeout_delay", cyc - last_fall_cyc, BIT, 3);
        end
      end
      if (p_err) chk("idle_after_timeout", busy, 0);
      if (!busy) chk("oe_released_idle", {ps2_clk_oe, ps2_dat_oe}, 0);
      if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
      else if (inh_run > 0) begin
        chk("inhibit_len", inh_run, INH);
        inh_run = 0;
      end
      if (ps2_clk_oe && ps2_dat_oe) req_run++;
      if (p_clk_oe && !ps2_clk_oe) begin
        clk_rel_cyc = cyc;
        chk("req_len", req_run, 1);
        req_run = 0;
      end
      if (ps2_dat_oe != p_dat_oe) begin
        recent_fall = 1'b0;
        for (int i = 0; i < 5; i++) if (hist[i+1] && !hist[i]) recent_fall = 1'b1;
        legal = recent_fall | ps2_clk_oe | p_clk_oe | error_communication_timed_out | (busy != p_busy);
        chk("dat_oe_change_legal", legal, 1);
      end
    end
    p_clk_oe = ps2_clk_oe;
    p_dat_oe = ps2_dat_oe;
    p_busy   = busy;
    p_err    = error_communication_timed_out;
    p_pulse  = command_was_sent | tx_nack | error_communication_timed_out;
  end

  // Device: waits for request-to-send, clocks nf falls, samples data on each rise, ACKs on fall 11.
  task automatic device(input int nf, input bit ack);
    int t = 0;
    dev_obs = '0;
    while (!(line_clk && !line_dat) && t < INH + 50) begin
      tick();
      t++;
    end
    chk("rts_seen", int'(t < INH + 50), 1);
    dev_obs[0] = line_dat;
    for (int f = 1; f <= nf; f++) begin
      if (f == 11 && ack) dev_dat_low = 1'b1;
      repeat (H) tick();
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      if (f == nf && nf < 11) return;
      repeat (H) tick();
      if (f <= 10) dev_obs[f] = line_dat;
      dev_clk_low = 1'b0;
      if (f == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int nf, input bit ack, input int kind,
                            input bit hold, input bit poke);
    if (kind != 0) exp_q.push_back(kind);
    the_command = b;
    send_command = 1'b1;
    if (!hold) begin
      tick();
      send_command = 1'b0;
    end
    fork
      device(nf, ack);
      if (poke) begin
        repeat (INH / 2) tick();
        the_command = 8'hAA;
        send_command = 1'b1;
        repeat (3) tick();
        send_command = 1'b0;
      end
    join
  endtask

  task automatic wait_idle(input string name, input int limit);
    int t = 0;
    while (busy && t < limit) begin
      tick();
      t++;
    end
    chk(name, busy, 0);
    tick();
  endtask

  task automatic check_frame(input logic [7:0] b);
    chk("start_bit", dev_obs[0], 0);
    chk("data_byte", dev_obs[8:1], b);
    chk("parity_bit", dev_obs[9], ($countones(b) % 2 == 0) ? 1 : 0);
    chk("stop_bit", dev_obs[10], 1);
  endtask

  initial begin
    repeat (60000) @(posedge CLOCK_50);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, b2;
    int seen;
    repeat (5) tick();
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", command_was_sent, 0);
    chk("rst_nack", tx_nack, 0);
    chk("rst_timeout", error_communication_timed_out, 0);
    resetn = 1'b1;
    tick();

    send_frame(8'hED, 11, 1, K_SENT, 0, 0);
    wait_idle("done_ed", 200);
    check_frame(8'hED);
    chk("ed_frame_literal", dev_obs, 11'b11111011010);
    chk("queue_ed", exp_q.size(), 0);

    send_frame(8'hF4, 11, 1, K_SENT, 0, 0);
    wait_idle("done_f4", 200);
    check_frame(8'hF4);
    chk("f4_parity_literal", dev_obs[9], 0);

    send_frame(8'h00, 11, 1, K_SENT, 0, 0);
    wait_idle("done_00", 200);
    check_frame(8'h00);
    chk("00_parity_literal", dev_obs[9], 1);

    to_mode = 1;
    send_frame(8'hF4, 0, 1, K_TO, 0, 0);
    wait_idle("done_start_to", 2000);
    chk("queue_start_to", exp_q.size(), 0);
    chk("oe_after_start_to", {ps2_clk_oe, ps2_dat_oe}, 0);

    to_mode = 2;
    send_frame(8'($urandom), 4, 1, K_TO, 0, 0);
    wait_idle("done_bit_to", 2000);
    dev_clk_low = 1'b0;
    chk("queue_bit_to", exp_q.size(), 0);

    b = 8'($urandom);
    send_frame(b, 11, 0, K_NACK, 0, 0);
    wait_idle("done_nack", 200);
    check_frame(b);
    chk("queue_nack", exp_q.size(), 0);

    send_frame(8'h5A, 6, 1, 0, 0, 0);
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    chk("midrst_clk_oe", ps2_clk_oe, 0);
    chk("midrst_dat_oe", ps2_dat_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulses", {command_was_sent, tx_nack, error_communication_timed_out}, 0);
    resetn = 1'b1;
    dev_clk_low = 1'b0;
    repeat (20) tick();
    chk("quiet_after_reset", busy, 0);
    send_frame(8'hFF, 11, 1, K_SENT, 0, 0);
    wait_idle("done_ff", 200);
    check_frame(8'hFF);

    b = 8'h3C;
    send_frame(b, 11, 1, K_SENT, 0, 1);
    wait_idle("done_poke", 200);
    check_frame(b);
    seen = 0;
    repeat (3 * INH) begin
      tick();
      if (busy || ps2_clk_oe) seen++;
    end
    chk("no_queued_send", seen, 0);

    b  = 8'($urandom);
    b2 = 8'($urandom);
    send_frame(b, 11, 1, K_SENT, 1, 0);
    the_command = b2;
    wait_idle("done_hold1", 200);
    chk("retrigger_busy", busy, 1);
    send_command = 1'b0;
    check_frame(b);
    exp_q.push_back(K_SENT);
    device(11, 1);
    wait_idle("done_hold2", 200);
    check_frame(b2);

    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_frame(b, 11, 1, K_SENT, 0, 0);
      wait_idle("done_rand", 200);
      check_frame(b);
    end

    repeat (5) tick();
    chk("queue_final", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 keyboard port, built to the IEEE-less de facto PS/2 host-send protocol.
- Sends one command byte per request, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Drives the open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables; the receive path on the same lines is unchanged.
- Sits beside the keyboard receiver in the top level and reports completion, missing ACK, or timeout.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low hold before start, 100 us at 50 MHz.
- START_TIMEOUT, 750000: maximum wait from clock release to the first device falling edge, 15 ms.
- BIT_TIMEOUT, 100000: maximum wait between consecutive device falling edges, 2 ms.
- TIMER_W, 20: width of the shared timeout counter; must satisfy 2^TIMER_W > every count above.

Ports:
- CLOCK_50, in, 1: system clock.
- resetn, in, 1: synchronous, active-low reset.
- the_command, in, 8: byte to send; captured when the request is accepted.
- send_command, in, 1: request, level-sampled; accepted only in IDLE.
- ps2_clk_in, in, 1: raw PS2_CLK pin value (asynchronous).
- ps2_dat_in, in, 1: raw PS2_DAT pin value (asynchronous).
- ps2_clk_oe, out, 1: 1 = pull PS2_CLK low; 0 = release (high-Z).
- ps2_dat_oe, out, 1: 1 = pull PS2_DAT low; 0 = release (high-Z).
- busy, out, 1: high in every state except IDLE.
- command_was_sent, out, 1: one-cycle pulse, byte sent and ACK seen.
- tx_nack, out, 1: one-cycle pulse, ACK bit sampled high.
- error_communication_timed_out, out, 1: one-cycle pulse on any timeout.

Behaviour:
- Input sync: 2-flop synchronizer on both pins, then a third register for edge detect. fall = prev & ~cur on the synced clock. Latency is 2 cycles from pin to fall.
- Reset values: every output is 0, the FSM is in IDLE, the shift register, bit count and timer are 0.
- Reset asserted mid-operation returns to IDLE on the next edge and releases both lines immediately. No pulse is emitted.
- Frame: start bit 0, d0..d7 LSB first, odd parity (~^the_command), stop bit 1. The device then returns an ACK (data low).
- IDLE: both oe = 0. If send_command = 1, latch {stop=1, parity, the_command} into a 10-bit shift register, clear timer and bit count, and go to INHIBIT.
- INHIBIT: clk_oe = 1, dat_oe = 0. After INHIBIT_CYCLES cycles go to REQ.
- REQ: clk_oe = 1, dat_oe = 1 (start bit), held for 1 cycle. Then go to WAIT_FIRST.
- WAIT_FIRST: clk_oe = 0, dat_oe = 1.
  - On fall: dat_oe = ~shift[0], shift right, count = 1, go to DATA.
  - If the timer reaches START_TIMEOUT with no fall: go to TIMEOUT.
- DATA: data changes only on fall; the device samples on rise.
  - On each fall: present the next bit (dat_oe = ~bit), increment count, restart the timer.
  - Falls 1..8 present d0..d7, fall 9 presents parity, fall 10 presents stop (dat_oe = 0).
  - After the stop bit is presented (count = 10), go to WAIT_ACK.
  - The timer exceeding BIT_TIMEOUT between falls goes to TIMEOUT.
- WAIT_ACK: both oe = 0.
  - On fall 11, sample synced data. 0 goes to WAIT_IDLE; 1 pulses tx_nack and goes to IDLE.
  - BIT_TIMEOUT with no fall goes to TIMEOUT.
- WAIT_IDLE: wait until synced clk = 1 and data = 1, then pulse command_was_sent and go to IDLE. A BIT_TIMEOUT expiry here goes to TIMEOUT.
- TIMEOUT: both oe = 0, pulse error_communication_timed_out for 1 cycle, then go to IDLE.
- The timer saturates and never wraps.
- send_command held high re-triggers a new send on the first IDLE cycle after completion. Requests while busy = 1 are ignored and not queued; the_command changes while busy have no effect.
- A fall in the same cycle as a timer expiry: the fall wins, the timer restarts and no timeout is raised.
- dat_oe must never change except on a fall cycle or a state transition.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing. Expect:
  - clk_oe low for 5000 cycles;
  - observed data bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1;
  - command_was_sent pulses once, busy falls in the same cycle.
- Send 0xF4: parity bit = 0 (five ones). Send 0x00: parity bit = 1. In both, the device model decodes the byte equal to the input and ACKs.
- Device never clocks after release → error_communication_timed_out pulses exactly 750000 cycles (±3) after clk_oe falls. Both oe = 0 afterwards, busy = 0.
- Device stops after fall 4 → timeout pulse 100000 cycles (±3) after the last fall. Device leaves data high at fall 11 → tx_nack pulses once, with no command_was_sent.
- Assert resetn = 0 during DATA at fall 6 → next cycle both oe = 0, busy = 0, no pulses. A new send of 0xFF afterwards completes correctly.
- Pulse send_command with 0xAA while busy → ignored; exactly one frame (the original byte) is transmitted.
